alu_sekwenser: RTL and testbench

Multi-byte sequencer for the 8-bit ALU `main`, which has operands `liczbaA`/`liczbaB`, op select `wybor`, carry-in `bitP`, result `wynik`, and flags `C`/`EVEN`/`Z`/`OV`. It accepts one wide operation (8·N_BAJTOW bits) over a valid/ready handshake. It executes the operation as N_BAJTOW back-to-back byte passes through the shared ALU, LSB byte first, chaining carry through `bitP`. It then holds the assembled result and combined flags until the consumer takes them.

---
 rtl/alu_sekwenser.sv | 117 +++++++++++
 tb/tb_alu_sekwenser.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sekwenser.sv
// Multi-byte sequencer around a shared combinational 8-bit ALU: one wide op per
// handshake, executed LSB byte first with the carry chained through alu_bitP.
//
// state    | meaning
// IDLE     | waiting for a request, start_ready high
// PRZEBIEG | one byte pass per cycle through the ALU, pass index k
// GOTOWE   | assembled result and flags held until wynik_ready
module alu_sekwenser #(
    parameter int N_BAJTOW = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [8*N_BAJTOW-1:0]   argA,
    input  logic [8*N_BAJTOW-1:0]   argB,
    input  logic [1:0]              op,
    input  logic                    cin,
    output logic                    wynik_valid,
    input  logic                    wynik_ready,
    output logic [8*N_BAJTOW-1:0]   wynik,
    output logic                    C,
    output logic                    Z,
    output logic                    OV,
    output logic                    EVEN,
    output logic [7:0]              alu_A,
    output logic [7:0]              alu_B,
    output logic [1:0]              alu_wybor,
    output logic                    alu_bitP,
    input  logic [7:0]              alu_wynik,
    input  logic                    alu_C,
    input  logic                    alu_Z,
    input  logic                    alu_OV,
    input  logic                    alu_EVEN
);
    localparam int W = 8 * N_BAJTOW;
    localparam logic [1:0] K_LAST = 2'(N_BAJTOW - 1);

    typedef enum logic [1:0] {IDLE, PRZEBIEG, GOTOWE} stan_t;

    stan_t        stan;
    logic [1:0]   k;
    logic [W-1:0] a_sh;
    logic [W-1:0] b_sh;

    assign start_ready = rst_n && (stan == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stan        <= IDLE;
            k           <= 2'd0;
            a_sh        <= '0;
            b_sh        <= '0;
            wynik       <= '0;
            C           <= 1'b0;
            Z           <= 1'b0;
            OV          <= 1'b0;
            EVEN        <= 1'b0;
            wynik_valid <= 1'b0;
            alu_A       <= 8'd0;
            alu_B       <= 8'd0;
            alu_wybor   <= 2'd0;
            alu_bitP    <= 1'b0;
        end else begin
            case (stan)
                IDLE: begin
                    if (start_valid) begin
                        // ALU inputs are registered, so byte 0 is presented right at accept
                        alu_A     <= argA[7:0];
                        alu_B     <= argB[7:0];
                        alu_wybor <= op;
                        alu_bitP  <= cin;
                        a_sh      <= argA >> 8;
                        b_sh      <= argB >> 8;
                        k         <= 2'd0;
                        stan      <= PRZEBIEG;
                    end
                end
                PRZEBIEG: begin
                    for (int i = 0; i < N_BAJTOW; i++) begin
                        if (k == 2'(i)) wynik[8*i +: 8] <= alu_wynik;
                    end
                    C  <= alu_C;
                    OV <= alu_OV;
                    if (k == 2'd0) begin
                        Z    <= alu_Z;
                        EVEN <= alu_EVEN;
                    end else begin
                        Z <= Z & alu_Z;
                    end
                    if (k == K_LAST) begin
                        alu_A       <= 8'd0;
                        alu_B       <= 8'd0;
                        alu_wybor   <= 2'd0;
                        alu_bitP    <= 1'b0;
                        wynik_valid <= 1'b1;
                        stan        <= GOTOWE;
                    end else begin
                        alu_A    <= a_sh[7:0];
                        alu_B    <= b_sh[7:0];
                        alu_bitP <= alu_C;
                        a_sh     <= a_sh >> 8;
                        b_sh     <= b_sh >> 8;
                        k        <= k + 2'd1;
                    end
                end
                GOTOWE: begin
                    if (wynik_ready) begin
                        wynik_valid <= 1'b0;
                        stan        <= IDLE;
                    end
                end
                default: stan <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sekwenser.sv
// Bench for alu_sekwenser: N_BAJTOW=2 and N_BAJTOW=1 instances, each wired to a
// behavioural 8-bit ALU; results compared with a whole-word arithmetic model.
module tb_alu_sekwenser;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // N_BAJTOW = 2 instance
    logic        sv2 = 0, sr2, wv2, wr2 = 0, cin2 = 0, c2, z2, ov2, ev2, ap2, aC2, aZ2, aOV2, aE2;
    logic [15:0] a2 = 0, b2 = 0, w2;
    logic [1:0]  op2 = 0, aw2;
    logic [7:0]  aA2, aB2, aR2;
    // N_BAJTOW = 1 instance
    logic        sv1 = 0, sr1, wv1, wr1 = 0, cin1 = 0, c1, z1, ov1, ev1, ap1, aC1, aZ1, aOV1, aE1;
    logic [7:0]  a1 = 0, b1 = 0, w1;
    logic [1:0]  op1 = 0, aw1;
    logic [7:0]  aA1, aB1, aR1;

    // Bench ALU: 00 add with carry, 01 and, 10 xor, 11 or; returns {C,Z,OV,EVEN,wynik}
    function automatic logic [11:0] alu_byte(input logic [7:0] a, input logic [7:0] b,
                                             input logic [1:0] w, input logic p);
        logic [8:0] s;
        logic [7:0] r;
        logic       c, ov;
        c = 1'b0;
        ov = 1'b0;
        case (w)
            2'b00: begin
                s = {1'b0, a} + {1'b0, b} + 9'(p);
                r = s[7:0];
                c = s[8];
                ov = (a[7] == b[7]) && (r[7] != a[7]);
            end
            2'b01:   r = a & b;
            2'b10:   r = a ^ b;
            default: r = a | b;
        endcase
        return {c, (r == 8'd0), ov, ~r[0], r};
    endfunction

    assign {aC2, aZ2, aOV2, aE2, aR2} = alu_byte(aA2, aB2, aw2, ap2);
    assign {aC1, aZ1, aOV1, aE1, aR1} = alu_byte(aA1, aB1, aw1, ap1);

    // Whole-word reference: {C,Z,OV,EVEN,result[31:0]} for an n-byte operation
    function automatic logic [35:0] ref_model(input logic [31:0] a_in, input logic [31:0] b_in,
                                              input logic [1:0] op, input logic cin, input int n);
        logic [32:0] sum;
        logic [31:0] mask, a, b, r;
        logic        c, ov;
        int          msb;
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        a = a_in & mask;
        b = b_in & mask;
        msb = 8 * n - 1;
        c = 1'b0;
        ov = 1'b0;
        case (op)
            2'b00: begin
                sum = {1'b0, a} + {1'b0, b} + 33'(cin);
                c = sum[8 * n];
                r = sum[31:0] & mask;
                ov = (a[msb] == b[msb]) && (r[msb] != a[msb]);
            end
            2'b01:   r = a & b;
            2'b10:   r = a ^ b;
            default: r = a | b;
        endcase
        return {c, (r == 32'd0), ov, ~r[0], r};
    endfunction

    alu_sekwenser #(.N_BAJTOW(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv2), .start_ready(sr2),
        .argA(a2), .argB(b2), .op(op2), .cin(cin2),
        .wynik_valid(wv2), .wynik_ready(wr2), .wynik(w2),
        .C(c2), .Z(z2), .OV(ov2), .EVEN(ev2),
        .alu_A(aA2), .alu_B(aB2), .alu_wybor(aw2), .alu_bitP(ap2),
        .alu_wynik(aR2), .alu_C(aC2), .alu_Z(aZ2), .alu_OV(aOV2), .alu_EVEN(aE2)
    );

    alu_sekwenser #(.N_BAJTOW(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv1), .start_ready(sr1),
        .argA(a1), .argB(b1), .op(op1), .cin(cin1),
        .wynik_valid(wv1), .wynik_ready(wr1), .wynik(w1),
        .C(c1), .Z(z1), .OV(ov1), .EVEN(ev1),
        .alu_A(aA1), .alu_B(aB1), .alu_wybor(aw1), .alu_bitP(ap1),
        .alu_wynik(aR1), .alu_C(aC1), .alu_Z(aZ1), .alu_OV(aOV1), .alu_EVEN(aE1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request to the 2-byte instance (assumed idle) and wait for wynik_valid.
    // lat counts cycles after the accept edge; drv0/drv1 are {alu_A,alu_B,alu_bitP} per pass.
    task automatic run2(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                        input logic cin, output int lat, output logic [16:0] drv0,
                        output logic [16:0] drv1);
        sv2 = 1'b1; a2 = a; b2 = b; op2 = op; cin2 = cin;
        step();
        sv2 = 1'b0;
        lat = 1;
        drv0 = '0;
        drv1 = '0;
        while (wv2 !== 1'b1 && lat < 20) begin
            if (lat == 1) drv0 = {aA2, aB2, ap2};
            if (lat == 2) drv1 = {aA2, aB2, ap2};
            step();
            lat++;
        end
    endtask

    task automatic handoff2();
        wr2 = 1'b1;
        step();
        wr2 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({sr2, wv2, w2, c2, z2, ov2, ev2, aA2, aB2, aw2, ap2} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got ready=%b valid=%b wynik=%h alu=%h/%h", sr2, wv2, w2, aA2, aB2);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({sr2, wv2, sr1, wv1} !== 4'b1010) begin
            failures++;
            $display("FAIL reset_release got sr2=%b wv2=%b sr1=%b wv1=%b want 1 0 1 0", sr2, wv2, sr1, wv1);
        end
    endtask

    task automatic test_carry_chain();
        int lat;
        logic [16:0] d0, d1;
        run2(16'h00FF, 16'h0001, 2'b00, 1'b0, lat, d0, d1);
        checks++;
        if (d0 !== {8'hFF, 8'h01, 1'b0}) begin
            failures++;
            $display("FAIL chain_pass0 got %h want %h", d0, {8'hFF, 8'h01, 1'b0});
        end
        checks++;
        if (d1 !== {8'h00, 8'h00, 1'b1}) begin
            failures++;
            $display("FAIL chain_pass1 got %h want %h", d1, {8'h00, 8'h00, 1'b1});
        end
        checks++;
        if (lat != 3) begin
            failures++;
            $display("FAIL chain_latency got %0d want 3", lat);
        end
        checks++;
        if ({w2, c2, z2, ev2} !== {16'h0100, 3'b001}) begin
            failures++;
            $display("FAIL chain_result got wynik=%h C=%b Z=%b EVEN=%b want 0100 0 0 1", w2, c2, z2, ev2);
        end
        handoff2();
        checks++;
        if ({wv2, sr2} !== 2'b01) begin
            failures++;
            $display("FAIL chain_handoff got valid=%b ready=%b want 0 1", wv2, sr2);
        end
    endtask

    task automatic test_wrap_and_z();
        int lat;
        logic [16:0] d0, d1;
        run2(16'hFFFF, 16'h0001, 2'b00, 1'b0, lat, d0, d1);
        checks++;
        if ({w2, c2, z2} !== {16'h0000, 2'b11}) begin
            failures++;
            $display("FAIL wrap_result got wynik=%h C=%b Z=%b want 0000 1 1", w2, c2, z2);
        end
        handoff2();
        run2(16'h0100, 16'h0000, 2'b00, 1'b0, lat, d0, d1);
        checks++;
        if ({w2, z2} !== {16'h0100, 1'b0}) begin
            failures++;
            $display("FAIL zcomb_result got wynik=%h Z=%b want 0100 0", w2, z2);
        end
        handoff2();
    endtask

    task automatic test_random();
        int lat;
        logic [16:0] d0, d1;
        logic [15:0] a, b;
        logic [1:0]  op;
        logic        cin;
        logic [35:0] exp;
        for (int i = 0; i < 24; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            op = 2'($urandom_range(0, 3));
            cin = 1'($urandom);
            if (i < 4) op = 2'b00;
            exp = ref_model({16'd0, a}, {16'd0, b}, op, cin, 2);
            run2(a, b, op, cin, lat, d0, d1);
            checks++;
            if (lat != 3 || w2 !== exp[15:0] || {c2, z2, ov2, ev2} !== exp[35:32]) begin
                failures++;
                $display("FAIL random_%0d op=%b a=%h b=%h cin=%b got lat=%0d wynik=%h CZOE=%b want wynik=%h CZOE=%b",
                         i, op, a, b, cin, lat, w2, {c2, z2, ov2, ev2}, exp[15:0], exp[35:32]);
            end
            checks++;
            if ({aA2, aB2, aw2, ap2, sr2} !== '0) begin
                failures++;
                $display("FAIL random_alu_idle_%0d got A=%h B=%h w=%b p=%b ready=%b want zeros", i, aA2, aB2, aw2, ap2, sr2);
            end
            handoff2();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [16:0] d0, d1;
        logic [15:0] hw, x;
        logic [3:0]  hf;
        logic [35:0] exp;
        run2(16'h1234, 16'h4321, 2'b00, 1'b1, lat, d0, d1);
        hw = w2;
        hf = {c2, z2, ov2, ev2};
        sv2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a2 = 16'($urandom);
            step();
            checks++;
            if (w2 !== hw || {c2, z2, ov2, ev2} !== hf || sr2 !== 1'b0 || wv2 !== 1'b1) begin
                failures++;
                $display("FAIL backpressure_hold_%0d got wynik=%h flags=%b ready=%b valid=%b want %h %b 0 1",
                         i, w2, {c2, z2, ov2, ev2}, sr2, wv2, hw, hf);
            end
        end
        x = 16'h80C3;
        a2 = x; b2 = 16'h7F3D; op2 = 2'b00; cin2 = 1'b0;
        handoff2();
        checks++;
        if ({wv2, sr2} !== 2'b01) begin
            failures++;
            $display("FAIL backpressure_idle got valid=%b ready=%b want 0 1", wv2, sr2);
        end
        step();
        sv2 = 1'b0;
        checks++;
        if ({sr2, aA2, aB2} !== {1'b0, 8'hC3, 8'h3D}) begin
            failures++;
            $display("FAIL backpressure_accept got ready=%b A=%h B=%h want 0 c3 3d", sr2, aA2, aB2);
        end
        lat = 1;
        while (wv2 !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        exp = ref_model({16'd0, x}, 32'h7F3D, 2'b00, 1'b0, 2);
        checks++;
        if (lat != 3 || w2 !== exp[15:0] || {c2, z2, ov2, ev2} !== exp[35:32]) begin
            failures++;
            $display("FAIL backpressure_second got lat=%0d wynik=%h flags=%b want 3 %h %b",
                     lat, w2, {c2, z2, ov2, ev2}, exp[15:0], exp[35:32]);
        end
        handoff2();
    endtask

    task automatic test_back_to_back();
        int nvalid = 0;
        int bad = 0;
        logic [35:0] exp;
        exp = ref_model(32'hA5F0, 32'h5A1F, 2'b00, 1'b1, 2);
        sv2 = 1'b1; a2 = 16'hA5F0; b2 = 16'h5A1F; op2 = 2'b00; cin2 = 1'b1;
        wr2 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (wv2 === 1'b1) begin
                nvalid++;
                if (w2 !== exp[15:0] || {c2, z2, ov2, ev2} !== exp[35:32]) bad++;
            end
            if (wv2 === 1'b1 && sr2 === 1'b1) bad++;
            step();
        end
        sv2 = 1'b0;
        step();
        wr2 = 1'b0;
        checks++;
        if (nvalid != 10 || bad != 0) begin
            failures++;
            $display("FAIL back_to_back got results=%0d errors=%0d want 10 0", nvalid, bad);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        sv2 = 1'b1; a2 = 16'h1111; b2 = 16'h2222; op2 = 2'b00; cin2 = 1'b0;
        step();
        sv2 = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        checks++;
        if ({sr2, wv2, w2, c2, z2, ov2, ev2, aA2, aB2, aw2, ap2} !== '0) begin
            failures++;
            $display("FAIL reset_mid got ready=%b valid=%b wynik=%h alu=%h/%h/%b", sr2, wv2, w2, aA2, aB2, ap2);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (wv2 !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0 || sr2 !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_after got valid_cycles=%0d ready=%b want 0 1", seen, sr2);
        end
    endtask

    task automatic test_n1();
        int lat;
        sv1 = 1'b1; a1 = 8'hFF; b1 = 8'h01; op1 = 2'b00; cin1 = 1'b1;
        step();
        sv1 = 1'b0;
        lat = 1;
        checks++;
        if ({aA1, aB1, ap1} !== {8'hFF, 8'h01, 1'b1}) begin
            failures++;
            $display("FAIL n1_pass0 got A=%h B=%h p=%b want ff 01 1", aA1, aB1, ap1);
        end
        while (wv1 !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        checks++;
        if (lat != 2 || {w1, c1} !== {8'h01, 1'b1}) begin
            failures++;
            $display("FAIL n1_result got lat=%0d wynik=%h C=%b want 2 01 1", lat, w1, c1);
        end
        wr1 = 1'b1;
        step();
        wr1 = 1'b0;
        checks++;
        if ({wv1, sr1} !== 2'b01) begin
            failures++;
            $display("FAIL n1_handoff got valid=%b ready=%b want 0 1", wv1, sr1);
        end
    endtask

    initial begin
        test_reset();
        test_carry_chain();
        test_wrap_and_z();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_n1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
